// File: rtl/onehot_to_binary_encoder_pkg.sv
// Shared definitions for the 2-to-4 select decoder / 4-to-2 request encoder pair:
// FSM state encoding and the one-hot check/encode helpers.
package onehot_to_binary_encoder_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        DEBOUNCE = ST_DEBOUNCE,
        HOLD     = ST_HOLD
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Valid only for one-hot input; a multi-hot vector ORs the codes together.
    function automatic logic [1:0] enc4to2(input logic [3:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction

endpackage

// File: rtl/onehot_to_binary_encoder_if.sv
// Request/code bundle of the one-hot encoder. The master drives the raw request
// lines; the slave (the encoder) returns the code and status strobes.
interface onehot_to_binary_encoder_if;

    logic Input_3;
    logic Input_2;
    logic Input_1;
    logic Input_0;
    logic Code_1;
    logic Code_0;
    logic Valid;
    logic Multi_Error;
    logic Busy;

    modport master (
        output Input_3, Input_2, Input_1, Input_0,
        input  Code_1, Code_0, Valid, Multi_Error, Busy
    );

    modport slave (
        input  Input_3, Input_2, Input_1, Input_0,
        output Code_1, Code_0, Valid, Multi_Error, Busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous board inputs.
// Each bit is synchronised separately; no cross-bit coherence is implied.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = D;
        sync_d = meta_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign Q = sync_q;

endmodule

// File: rtl/onehot_to_binary_encoder.sv
// Synchronises and debounces four request lines, then encodes a stable one-hot
// pattern to a 2-bit code with a Valid strobe, or flags a multi-hot pattern.
module onehot_to_binary_encoder
    import onehot_to_binary_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    onehot_to_binary_encoder_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << CNT_W) - 1) begin : g_bad_param
        $error("DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic [3:0] raw;
    logic [3:0] s;

    assign raw = {bus.Input_3, bus.Input_2, bus.Input_1, bus.Input_0};

    sync_2ff #(.WIDTH(4)) u_sync (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .D     (raw),
        .Q     (s)
    );

    state_t           state_q, state_d;
    logic [3:0]       cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       code_q,  code_d;
    logic             valid_q, valid_d;
    logic             merr_q,  merr_d;
    logic             busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        merr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (s != 4'd0) begin
                    cand_d  = s;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (s == 4'd0) begin
                    state_d = IDLE;
                end else if (s != cand_q) begin
                    cand_d = s;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                    if (is_onehot4(cand_q)) begin
                        code_d  = enc4to2(cand_q);
                        valid_d = 1'b1;
                    end else begin
                        merr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HOLD: begin
                // Any activity restarts the release window; only a full quiet
                // period re-arms the encoder for the next press.
                if (s != 4'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
            merr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            merr_q  <= merr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.Code_1      = code_q[1];
    assign bus.Code_0      = code_q[0];
    assign bus.Valid       = valid_q;
    assign bus.Multi_Error = merr_q;
    assign bus.Busy        = busy_q;

endmodule

// File: doc/onehot_to_binary_encoder.md
Name: onehot_to_binary_encoder

Overview:
4-line one-hot request encoder: the inverse of the team's 2-to-4 select decoder. It takes four asynchronous request lines (board buttons or decoder outputs), synchronises and debounces them, and encodes the single active line to a 2-bit code. It emits a one-cycle Valid strobe per accepted press and a one-cycle Multi_Error strobe when the stable pattern is not one-hot. It sits between raw board inputs and any logic consuming a binary select.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or a release; legal range 2..(2^CNT_W - 1).
CNT_W, 5, width of the debounce counter.

Ports:
Clk  input  1  system clock; all flops rising-edge.
Rst_n  input  1  asynchronous, active-low reset.
Input_3  input  1  request line 3; asynchronous to Clk.
Input_2  input  1  request line 2; asynchronous.
Input_1  input  1  request line 1; asynchronous.
Input_0  input  1  request line 0; asynchronous.
Code_1  output  1  registered code MSB; holds the last accepted value.
Code_0  output  1  registered code LSB; holds the last accepted value.
Valid  output  1  one-cycle pulse when a new Code is loaded.
Multi_Error  output  1  one-cycle pulse when the stable pattern has more than one line high.
Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous and active-low. While Rst_n=0, all flops clear immediately: both synchroniser stages, candidate, counter, Code=2'b00, Valid=0, Multi_Error=0, Busy=0, state=IDLE.
- Synchroniser: each line passes through a 2-flop stage. s[3:0] is the second-stage vector.
- FSM states: IDLE, DEBOUNCE, HOLD.
- IDLE: if s==0, stay in IDLE. Otherwise capture cand<=s, cnt<=0, and go to DEBOUNCE.
- DEBOUNCE, s==0: go to IDLE with no pulse (glitch rejected).
- DEBOUNCE, s!=cand and s!=0: set cand<=s, cnt<=0, stay (restart).
- DEBOUNCE, s==cand and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
- DEBOUNCE, s==cand and cnt==DEBOUNCE_CYCLES-1: set cnt<=0 and go to HOLD.
  - If cand is one-hot: Code_1<=cand[3]|cand[2], Code_0<=cand[3]|cand[1], and Valid<=1 for one cycle.
  - Otherwise: Multi_Error<=1 for one cycle and Code is unchanged.
- HOLD (release debounce): any s!=0 sets cnt<=0. Each cycle with s==0 increments cnt. When cnt==DEBOUNCE_CYCLES-1 with s==0, go to IDLE.
- No Valid or Multi_Error is issued in HOLD. A new press requires a full release first.
- Latency: with an input clean from before edge 0, Valid (or Multi_Error) is high for exactly the cycle after rising edge DEBOUNCE_CYCLES+3. This is 2 synchroniser edges plus 1 IDLE capture edge plus DEBOUNCE_CYCLES count edges.
- Valid and Multi_Error are mutually exclusive and never assert on consecutive cycles.
- Busy is registered from the next state, so it is high from the IDLE→DEBOUNCE edge until the HOLD→IDLE edge.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Reset mid-operation: all state is discarded and no pulse is issued. After Rst_n rises, a held input requires the full latency again.

Decomposition:
- Shared package:
  - State encoding localparams ST_IDLE=2'd0, ST_DEBOUNCE=2'd1, ST_HOLD=2'd2.
  - is_onehot4 function.
  - enc4to2 function.
  The decoder/encoder pair share these.
- Sub-module sync_2ff: parameter WIDTH, ports Clk, Rst_n, D, Q. Instantiated once with WIDTH=4. It is reusable for other board inputs.

Test Plan (DEBOUNCE_CYCLES=4):
1. Hold Rst_n=0 with Input_2=1 for 10 cycles -> Code=00, Valid=0, Multi_Error=0, Busy=0 throughout.
2. Input_2=1 clean for 20 cycles, then 0 -> a single Valid pulse in the cycle after edge 7 with Code=10. Busy falls 4 cycles after s clears.
3. Input_1 toggling every 2 cycles for 12 cycles, then held high -> no pulse during toggling, exactly one Valid, Code=01.
4. Input_1 high for 3 cycles, then switched directly to Input_3 and held -> counter restarts and one Valid with Code=11; code 01 is never emitted.
5. After Code=10, Input_3 and Input_0 held high together -> one Multi_Error pulse, no Valid, Code stays 10.
6. Input_0 held, Rst_n pulsed low during DEBOUNCE -> immediate Code=00 and Busy=0. After release, Valid arrives 7 edges later with Code=00.
